ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_pkg.sv | 27 ++
 rtl/ahb_slave_mem.sv | 33 +++
 rtl/ahb_sram_slave.sv | 145 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, response codes and slave FSM state encoding.
//   ADDR_W / DATA_W : bus address and data widths
//   HTRANS_*        : transfer type encodings
//   RESP_*          : HRESP codes
//   state_t         : data-phase sequencer states
package ahb_pkg;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BYTE_AW = 8;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_slave_mem.sv
// Byte-wide storage array: synchronous write, combinational read.
//   clk     : clock
//   we      : write enable, commits wdata at waddr on the rising edge
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite byte SRAM slave with programmable wait states and an
// out-of-range ERROR response.
//   HCLK, HRESET : clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE, HTRANS, HREADY : address phase inputs
//   HWDATA       : write data (data phase)
//   HRDATA       : read data, held between read completions
//   HREADYOUT    : slave ready
//   HRESP        : 0 = OKAY, 1 = ERROR
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]  WS     = 3'(WAIT_STATES);

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [BYTE_AW-1:0]   addr_q;
  logic                 write_q;
  logic                 valid_q;
  logic                 ok_q;

  logic                 capture_c;
  logic                 in_range_c;
  logic                 final_c;
  logic                 we_c;
  logic                 load_rd_c;
  logic [BYTE_AW-1:0]   rd_addr_c;
  logic [DATA_W-1:0]    mem_rdata_c;
  logic [DATA_W-1:0]    rd_next_c;

  assign capture_c  = HSEL && HREADY &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign in_range_c = (HADDR[ADDR_W-1:BYTE_AW] == '0) &&
                      ({1'b0, HADDR[BYTE_AW-1:0]} < 9'(MEM_DEPTH));

  // IDLE with a live in-range transfer is the final (HREADYOUT=1) data cycle;
  // transfers needing wait states or errors leave IDLE on their capture edge.
  assign final_c = (state_q == ST_IDLE) && valid_q && ok_q;
  assign we_c    = final_c && write_q && !HRESET;

  // Forward write data when a read completes on the cycle after a write to
  // the same byte (only reachable with zero wait states).
  assign rd_next_c = (we_c && (addr_q == rd_addr_c)) ? HWDATA : mem_rdata_c;

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, wait counter and read-load decision
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_rd_c = 1'b0;
    rd_addr_c = addr_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (capture_c) begin
          if (!in_range_c) begin
            state_d = ST_ERR1;
          end else if (WS == 3'd0) begin
            load_rd_c = !HWRITE;
            rd_addr_c = HADDR[BYTE_AW-1:0];
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d   = ST_IDLE;
          cnt_d     = 3'd0;
          load_rd_c = !write_q;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address-phase capture, counter and registered bus outputs
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q     <= 3'd0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      ok_q      <= 1'b0;
      HRDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= RESP_OKAY;
    end else begin
      cnt_q <= cnt_d;
      if (HREADY) begin
        valid_q <= capture_c;
        if (capture_c) begin
          addr_q  <= HADDR[BYTE_AW-1:0];
          write_q <= HWRITE;
          ok_q    <= in_range_c;
        end
      end
      HREADYOUT <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
      HRESP     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
      if (load_rd_c) begin
        HRDATA <= rd_next_c;
      end
    end
  end

  ahb_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (MEM_AW)
  ) u_mem (
    .clk     (HCLK),
    .we      (we_c),
    .waddr   (MEM_AW'(addr_q)),
    .wdata   (HWDATA),
    .raddr   (MEM_AW'(rd_addr_c)),
    .rdata_c (mem_rdata_c)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances (1, 3 and 0 wait states)
// share the address/data bus; each instance's HREADY is its own HREADYOUT.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       hreset;
  logic [2:0]       hsel;
  logic [20:0]      haddr;
  logic             hwrite;
  logic [1:0]       htrans;
  logic [7:0]       hwdata;
  logic [2:0][7:0]  hrdata;
  logic [2:0]       hreadyout;
  logic [2:0]       hresp;

  int checks = 0;
  int errors = 0;

  // Burst operation table and per-op observations
  logic        b_wr    [16];
  logic [20:0] b_addr  [16];
  logic [1:0]  b_trans [16];
  logic [7:0]  b_wd    [16];
  logic [7:0]  b_rd    [16];
  int          b_waits [16];
  logic        b_resp  [16];
  logic        b_werr  [16];

  ahb_sram_slave #(.WAIT_STATES(1), .MEM_DEPTH(256)) u_ws1 (
    .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr),
    .HWRITE(hwrite), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hreadyout[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_sram_slave #(.WAIT_STATES(3), .MEM_DEPTH(256)) u_ws3 (
    .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr),
    .HWRITE(hwrite), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hreadyout[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  ahb_sram_slave #(.WAIT_STATES(0), .MEM_DEPTH(256)) u_ws0 (
    .HCLK(clk), .HRESET(hreset[2]), .HSEL(hsel[2]), .HADDR(haddr),
    .HWRITE(hwrite), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hreadyout[2]),
    .HRDATA(hrdata[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic wr, input logic [20:0] a,
                        input logic [1:0] tr, input logic [7:0] wd);
    b_wr[i]    = wr;
    b_addr[i]  = a;
    b_trans[i] = tr;
    b_wd[i]    = wd;
  endtask

  task automatic drive_addr(input int d, input int i);
    hsel    = 3'b000;
    hsel[d] = 1'b1;
    haddr   = b_addr[i];
    hwrite  = b_wr[i];
    htrans  = b_trans[i];
  endtask

  task automatic drive_idle();
    hsel   = 3'b000;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Pipelined run of ops 0..n-1 against instance d; inputs change and outputs
  // are sampled on the falling edge.
  task automatic burst(input int d, input int n);
    int w;
    @(negedge clk);
    drive_addr(d, 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hwdata = b_wd[i];
      if (i + 1 < n) drive_addr(d, i + 1);
      else drive_idle();
      w = 0;
      b_werr[i] = 1'b0;
      while (!hreadyout[d] && w < 20) begin
        b_werr[i] = b_werr[i] | hresp[d];
        w++;
        @(negedge clk);
      end
      b_waits[i] = w;
      b_rd[i]    = hrdata[d];
      b_resp[i]  = hresp[d];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    hreset = 3'b111;
    drive_idle();
    haddr  = '0;
    hwdata = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("rst_resp%0d", d),  32'(hresp[d]),     32'd0);
      check($sformatf("rst_rdata%0d", d), 32'(hrdata[d]),    32'h00);
    end
    hreset = 3'b000;

    // One wait state: write A5 then read it back
    set_op(0, 1'b1, 21'h00010, HTRANS_NONSEQ, 8'hA5);
    burst(0, 1);
    check("ws1_wr_waits", 32'(b_waits[0]), 32'd1);
    check("ws1_wr_resp",  32'(b_resp[0]),  32'd0);
    set_op(0, 1'b0, 21'h00010, HTRANS_NONSEQ, 8'h00);
    burst(0, 1);
    check("ws1_rd_data",  32'(b_rd[0]),    32'hA5);
    check("ws1_rd_waits", 32'(b_waits[0]), 32'd1);
    check("ws1_rd_resp",  32'(b_resp[0]),  32'd0);

    // Back-to-back write then read of the same byte
    set_op(0, 1'b1, 21'h00020, HTRANS_NONSEQ, 8'h3C);
    set_op(1, 1'b0, 21'h00020, HTRANS_NONSEQ, 8'h00);
    burst(0, 2);
    check("ws1_b2b_data",  32'(b_rd[1]),    32'h3C);
    check("ws1_b2b_waits", 32'(b_waits[1]), 32'd1);

    // Out-of-range error response and BUSY with no side effects
    set_op(0, 1'b1, 21'h00000, HTRANS_NONSEQ, 8'hC3);
    set_op(1, 1'b1, 21'h00005, HTRANS_NONSEQ, 8'h5A);
    set_op(2, 1'b0, 21'h00100, HTRANS_NONSEQ, 8'h00);
    set_op(3, 1'b1, 21'h00100, HTRANS_NONSEQ, 8'hFF);
    set_op(4, 1'b1, 21'h00005, HTRANS_BUSY,   8'hEE);
    set_op(5, 1'b0, 21'h00000, HTRANS_NONSEQ, 8'h00);
    set_op(6, 1'b0, 21'h00005, HTRANS_NONSEQ, 8'h00);
    burst(0, 7);
    check("err_rd_waits",  32'(b_waits[2]), 32'd1);
    check("err_rd_resp1",  32'(b_werr[2]),  32'd1);
    check("err_rd_resp2",  32'(b_resp[2]),  32'd1);
    check("err_wr_resp2",  32'(b_resp[3]),  32'd1);
    check("busy_waits",    32'(b_waits[4]), 32'd0);
    check("busy_resp",     32'(b_resp[4]),  32'd0);
    check("err_no_alias",  32'(b_rd[5]),    32'hC3);
    check("busy_no_write", 32'(b_rd[6]),    32'h5A);
    check("ok_after_err",  32'(b_resp[6]),  32'd0);

    // Three wait states, then reset during a pending write
    set_op(0, 1'b1, 21'h00030, HTRANS_NONSEQ, 8'h11);
    set_op(1, 1'b0, 21'h00030, HTRANS_NONSEQ, 8'h00);
    burst(1, 2);
    check("ws3_wr_waits", 32'(b_waits[0]), 32'd3);
    check("ws3_rd_waits", 32'(b_waits[1]), 32'd3);
    check("ws3_rd_data",  32'(b_rd[1]),    32'h11);
    @(negedge clk);
    set_op(0, 1'b1, 21'h00030, HTRANS_NONSEQ, 8'h00);
    drive_addr(1, 0);
    @(negedge clk);
    drive_idle();
    hwdata = 8'h77;
    check("ws3_wait1_ready", 32'(hreadyout[1]), 32'd0);
    @(negedge clk);
    check("ws3_wait2_ready", 32'(hreadyout[1]), 32'd0);
    hreset[1] = 1'b1;
    @(negedge clk);
    check("ws3_rst_ready", 32'(hreadyout[1]), 32'd1);
    check("ws3_rst_resp",  32'(hresp[1]),     32'd0);
    check("ws3_rst_rdata", 32'(hrdata[1]),    32'h00);
    hreset[1] = 1'b0;
    set_op(0, 1'b0, 21'h00030, HTRANS_NONSEQ, 8'h00);
    burst(1, 1);
    check("ws3_discarded", 32'(b_rd[0]), 32'h11);

    // Zero wait states: ten SEQ writes then ten SEQ reads
    for (int i = 0; i < 10; i++)
      set_op(i, 1'b1, 21'(i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 8'(32'h40 + 3 * i));
    burst(2, 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("ws0_wr_waits%0d", i), 32'(b_waits[i]), 32'd0);
    for (int i = 0; i < 10; i++)
      set_op(i, 1'b0, 21'(i), (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 8'h00);
    burst(2, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ws0_rd_data%0d", i),  32'(b_rd[i]),    32'(8'(32'h40 + 3 * i)));
      check($sformatf("ws0_rd_waits%0d", i), 32'(b_waits[i]), 32'd0);
    end

    // Zero wait states: read immediately after write needs forwarding
    set_op(0, 1'b1, 21'h00020, HTRANS_NONSEQ, 8'h3C);
    set_op(1, 1'b0, 21'h00020, HTRANS_NONSEQ, 8'h00);
    set_op(2, 1'b1, 21'h00020, HTRANS_NONSEQ, 8'h96);
    set_op(3, 1'b0, 21'h00020, HTRANS_NONSEQ, 8'h00);
    burst(2, 4);
    check("ws0_b2b_data1", 32'(b_rd[1]), 32'h3C);
    check("ws0_b2b_data2", 32'(b_rd[3]), 32'h96);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
